// File: rtl/bsort_run_ctrl.sv
// bsort_run_ctrl: run sequencer for a byte-sorting accelerator.
// It accepts a command, streams the input vector into the accelerator's
// slave RAM, pulses start, waits for done (with a cycle budget), then reads
// the vector back one byte at a time and streams it out. Every run ends
// with a one-cycle run_done pulse and a status code.
module bsort_run_ctrl #(
    parameter int MEM_SIZE  = 256,
    parameter int ADDR_W    = 10,
    parameter int RUN_LIMIT = 200000000,
    parameter int RD_LIMIT  = 16
) (
    input  logic              clock,
    input  logic              reset,
    // command
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    // load stream
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    // result stream
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    // accelerator control
    output logic              start_port,
    input  logic              done_port,
    // accelerator slave RAM port
    output logic              S_oe_ram,
    output logic              S_we_ram,
    output logic [ADDR_W-1:0] S_addr_ram,
    output logic [7:0]        S_Wdata_ram,
    output logic [6:0]        S_data_ram_size,
    input  logic [7:0]        Sout_Rdata_ram,
    input  logic              Sout_DataRdy,
    // run status
    output logic              run_done,
    output logic [1:0]        run_err,
    output logic [31:0]       run_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_RUN     = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_OUT     = 3'd6,
        ST_FIN     = 3'd7
    } state_t;

    localparam int                RD_W        = (RD_LIMIT < 2) ? 1 : $clog2(RD_LIMIT);
    localparam logic [RD_W-1:0]   RD_LAST     = RD_W'(RD_LIMIT - 1);
    localparam logic [ADDR_W+1:0] MEM_SIZE_X  = (ADDR_W + 2)'(MEM_SIZE);
    localparam logic [31:0]       RUN_LIMIT_X = 32'(RUN_LIMIT);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_BAD_CMD = 2'd1;
    localparam logic [1:0] ERR_RUN_TO  = 2'd2;
    localparam logic [1:0] ERR_RD_TO   = 2'd3;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   base_reg;
    logic [ADDR_W:0]     len_reg;
    logic [ADDR_W:0]     ptr_reg;
    logic [31:0]         run_cycles_reg;
    logic [1:0]          err_reg;
    logic [RD_W-1:0]     rd_cnt_reg;
    logic [7:0]          rdata_reg;

    // Range check is done two bits wider than the address so neither the
    // length alone nor base+len can wrap and slip past the bound.
    logic [ADDR_W+1:0]   cmd_end;
    logic                cmd_bad;
    logic [ADDR_W:0]     ptr_inc;
    logic                ptr_last;
    logic [ADDR_W-1:0]   slave_addr;
    logic                run_timeout;

    assign cmd_end     = {2'b00, cmd_base} + {1'b0, cmd_len};
    assign cmd_bad     = ({1'b0, cmd_len} > MEM_SIZE_X) || (cmd_end > MEM_SIZE_X);
    assign ptr_inc     = ptr_reg + (ADDR_W + 1)'(1);
    assign ptr_last    = (ptr_inc == len_reg);
    assign slave_addr  = base_reg + ptr_reg[ADDR_W-1:0];
    assign run_timeout = (run_cycles_reg > RUN_LIMIT_X);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad)
                        state_next = ST_FIN;
                    else if (cmd_len == '0)
                        state_next = ST_START;
                    else
                        state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid && ptr_last)
                    state_next = ST_START;
            end
            ST_START: state_next = ST_RUN;
            ST_RUN: begin
                // done wins over a timeout detected in the same cycle
                if (done_port)
                    state_next = (len_reg == '0) ? ST_FIN : ST_RD_REQ;
                else if (run_timeout)
                    state_next = ST_FIN;
            end
            ST_RD_REQ: state_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (Sout_DataRdy)
                    state_next = ST_OUT;
                else if (rd_cnt_reg == RD_LAST)
                    state_next = ST_FIN;
            end
            ST_OUT: begin
                if (out_ready)
                    state_next = ptr_last ? ST_FIN : ST_RD_REQ;
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: command latch, byte pointer, cycle counter, read capture, status
    always_ff @(posedge clock) begin
        if (reset) begin
            base_reg       <= '0;
            len_reg        <= '0;
            ptr_reg        <= '0;
            run_cycles_reg <= '0;
            err_reg        <= ERR_OK;
            rd_cnt_reg     <= '0;
            rdata_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        base_reg       <= cmd_base;
                        len_reg        <= cmd_len;
                        ptr_reg        <= '0;
                        run_cycles_reg <= '0;
                        err_reg        <= cmd_bad ? ERR_BAD_CMD : ERR_OK;
                    end
                end
                ST_LOAD: begin
                    if (in_valid)
                        ptr_reg <= ptr_inc;
                end
                ST_START: run_cycles_reg <= 32'd1;
                ST_RUN: begin
                    if (run_cycles_reg != '1)
                        run_cycles_reg <= run_cycles_reg + 32'd1;
                    if (done_port)
                        ptr_reg <= '0;
                    else if (run_timeout)
                        err_reg <= ERR_RUN_TO;
                end
                ST_RD_REQ: rd_cnt_reg <= '0;
                ST_RD_WAIT: begin
                    if (Sout_DataRdy) begin
                        rdata_reg <= Sout_Rdata_ram;
                    end else begin
                        rd_cnt_reg <= rd_cnt_reg + RD_W'(1);
                        if (rd_cnt_reg == RD_LAST)
                            err_reg <= ERR_RD_TO;
                    end
                end
                ST_OUT: begin
                    if (out_ready)
                        ptr_reg <= ptr_inc;
                end
                default: ;
            endcase
        end
    end

    // Output decode: each strobe is driven only by the state that owns it
    always_comb begin
        cmd_ready       = 1'b0;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        out_data        = 8'h00;
        start_port      = 1'b0;
        S_oe_ram        = 1'b0;
        S_we_ram        = 1'b0;
        S_addr_ram      = '0;
        S_Wdata_ram     = 8'h00;
        S_data_ram_size = 7'd0;
        run_done        = 1'b0;
        case (state_reg)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    S_we_ram    = 1'b1;
                    S_addr_ram  = slave_addr;
                    S_Wdata_ram = in_data;
                end
            end
            ST_START: start_port = 1'b1;
            ST_RD_REQ: begin
                S_oe_ram   = 1'b1;
                S_addr_ram = slave_addr;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                out_data  = rdata_reg;
            end
            ST_FIN:  run_done = 1'b1;
            default: ;
        endcase
        if (S_oe_ram || S_we_ram)
            S_data_ram_size = 7'd8;
    end

    assign run_err    = err_reg;
    assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_bsort_run_ctrl.sv
// Directed bench for bsort_run_ctrl: slave RAM model with a one-cycle read
// response (which can be withheld), activity counters, and a linear script
// of runs covering normal, bad-command, empty, timeout and reset cases.
module tb_bsort_run_ctrl;

    localparam int ADDR_W = 10;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [ADDR_W:0]   cmd_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = 8'h00;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [7:0]        out_data;
    logic              start_port;
    logic              done_port = 1'b0;
    logic              S_oe_ram;
    logic              S_we_ram;
    logic [ADDR_W-1:0] S_addr_ram;
    logic [7:0]        S_Wdata_ram;
    logic [6:0]        S_data_ram_size;
    logic [7:0]        Sout_Rdata_ram;
    logic              Sout_DataRdy;
    logic              run_done;
    logic [1:0]        run_err;
    logic [31:0]       run_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    bsort_run_ctrl #(
        .MEM_SIZE (256),
        .ADDR_W   (ADDR_W),
        .RUN_LIMIT(20),
        .RD_LIMIT (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_base       (cmd_base),
        .cmd_len        (cmd_len),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .start_port     (start_port),
        .done_port      (done_port),
        .S_oe_ram       (S_oe_ram),
        .S_we_ram       (S_we_ram),
        .S_addr_ram     (S_addr_ram),
        .S_Wdata_ram    (S_Wdata_ram),
        .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram (Sout_Rdata_ram),
        .Sout_DataRdy   (Sout_DataRdy),
        .run_done       (run_done),
        .run_err        (run_err),
        .run_cycles     (run_cycles)
    );

    always #5 clock = ~clock;

    // Slave RAM model and activity monitor
    logic [7:0]        mem [1024];
    logic              rd_pend = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              withhold = 1'b0;
    int                oe_cnt = 0, we_cnt = 0, start_cnt = 0, both_cnt = 0;
    int                wr_addr_q[$];
    int                wr_data_q[$];

    assign Sout_DataRdy   = rd_pend;
    assign Sout_Rdata_ram = mem[rd_addr];

    always @(posedge clock) begin
        rd_pend <= S_oe_ram && !withhold;
        if (S_oe_ram) rd_addr <= S_addr_ram;
        if (S_we_ram) begin
            mem[S_addr_ram] <= S_Wdata_ram;
            wr_addr_q.push_back(int'(S_addr_ram));
            wr_data_q.push_back(int'(S_Wdata_ram));
            we_cnt++;
        end
        if (S_oe_ram) oe_cnt++;
        if (start_port) start_cnt++;
        if (S_oe_ram && S_we_ram) both_cnt++;
        if (run_done && !reset)
            $display("txn end: err=%0d cycles=%0d", run_err, run_cycles);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for out_valid; an expired bound is a failed check.
    task automatic wait_out(input string tag);
        int c;
        c = 0;
        while (!out_valid && c < 20) begin
            tick();
            c++;
        end
        if (!out_valid) chk(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic issue(input int base, input int len);
        cmd_valid = 1'b1;
        cmd_base  = ADDR_W'(base);
        cmd_len   = (ADDR_W + 1)'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    logic [7:0] s1_bytes [4];
    int oe0, we0, st0, wq0, cnt;

    initial begin
        s1_bytes[0] = 8'h04; s1_bytes[1] = 8'h03;
        s1_bytes[2] = 8'h02; s1_bytes[3] = 8'h01;

        // ---- reset state
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_run_done", 32'(run_done), 32'd0);
        chk("rst_run_err", 32'(run_err), 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        chk("rst_size", 32'(S_data_ram_size), 32'd0);

        // ---- S1: base 0, len 4, command issued on the first cycle out of reset
        reset = 1'b0;
        we0 = we_cnt; wq0 = wr_addr_q.size(); st0 = start_cnt;
        issue(0, 4);
        chk("s1_in_ready", 32'(in_ready), 32'd1);
        chk("s1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = s1_bytes[i];
            tick();
        end
        in_valid = 1'b0;
        chk("s1_start_port", 32'(start_port), 32'd1);
        chk("s1_we_count", 32'(we_cnt - we0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("s1_wr_addr", 32'(wr_addr_q[wq0 + i]), 32'(i));
            chk("s1_wr_data", 32'(wr_data_q[wq0 + i]), 32'(s1_bytes[i]));
        end
        repeat (10) tick();
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        chk("s1_run_cycles", run_cycles, 32'd11);
        chk("s1_rd_oe", 32'(S_oe_ram), 32'd1);
        chk("s1_rd_addr0", 32'(S_addr_ram), 32'd0);
        chk("s1_rd_size", 32'(S_data_ram_size), 32'd8);
        for (int i = 0; i < 4; i++) begin
            wait_out("s1_out_timeout");
            chk("s1_out_data", 32'(out_data), 32'(s1_bytes[i]));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("s1_run_done", 32'(run_done), 32'd1);
        chk("s1_run_err", 32'(run_err), 32'd0);
        chk("s1_start_count", 32'(start_cnt - st0), 32'd1);
        tick();
        chk("s1_idle_ready", 32'(cmd_ready), 32'd1);
        chk("s1_done_pulse", 32'(run_done), 32'd0);
        chk("s1_cycles_held", run_cycles, 32'd11);

        // ---- S2: bad command base 250 len 8
        oe0 = oe_cnt; we0 = we_cnt; st0 = start_cnt;
        issue(250, 8);
        chk("s2_run_done", 32'(run_done), 32'd1);
        chk("s2_run_err", 32'(run_err), 32'd1);
        tick();
        chk("s2_err_held", 32'(run_err), 32'd1);
        chk("s2_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("s2_no_oe", 32'(oe_cnt - oe0), 32'd0);
        chk("s2_no_we", 32'(we_cnt - we0), 32'd0);
        chk("s2_no_start", 32'(start_cnt - st0), 32'd0);

        // ---- S3: len 0, done after 2 RUN cycles
        oe0 = oe_cnt; we0 = we_cnt;
        issue(5, 0);
        chk("s3_start_port", 32'(start_port), 32'd1);
        chk("s3_err_cleared", 32'(run_err), 32'd0);
        tick();
        chk("s3_start_pulse", 32'(start_port), 32'd0);
        tick();
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        chk("s3_run_done", 32'(run_done), 32'd1);
        chk("s3_run_err", 32'(run_err), 32'd0);
        chk("s3_run_cycles", run_cycles, 32'd3);
        chk("s3_no_slave", 32'((oe_cnt - oe0) + (we_cnt - we0)), 32'd0);
        tick();

        // ---- S4: run timeout with RUN_LIMIT 20, done never asserted
        issue(0, 0);
        chk("s4_start_port", 32'(start_port), 32'd1);
        cnt = 0;
        while (!run_done && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("s4_fin_cycle", 32'(cnt), 32'd22);
        chk("s4_run_err", 32'(run_err), 32'd2);
        chk("s4_run_cycles", run_cycles, 32'd22);
        tick();

        // ---- S5: out_ready held low, then read data withheld
        issue(100, 2);
        in_valid = 1'b1; in_data = 8'hAA; tick();
        in_data = 8'hBB; tick();
        in_valid = 1'b0;
        tick();
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        chk("s5_rd_addr", 32'(S_addr_ram), 32'd100);
        oe0 = oe_cnt;
        wait_out("s5_out_timeout");
        chk("s5_out_data", 32'(out_data), 32'hAA);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s5_hold_valid", 32'(out_valid), 32'd1);
            chk("s5_hold_data", 32'(out_data), 32'hAA);
        end
        chk("s5_no_new_oe", 32'(oe_cnt - oe0), 32'd1);
        withhold  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("s5_rd2_oe", 32'(S_oe_ram), 32'd1);
        chk("s5_rd2_addr", 32'(S_addr_ram), 32'd101);
        cnt = 0;
        while (!run_done && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("s5_rd_to_cycle", 32'(cnt), 32'd17);
        chk("s5_run_err", 32'(run_err), 32'd3);
        withhold = 1'b0;
        tick();
        chk("s5_oe_total", 32'(oe_cnt - oe0), 32'd2);

        // ---- S6: reset mid-LOAD after 2 bytes, then a clean run
        issue(0, 4);
        in_valid = 1'b1; in_data = 8'h55; tick();
        in_data = 8'h66; tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("s6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("s6_rst_in_ready", 32'(in_ready), 32'd0);
        chk("s6_rst_err", 32'(run_err), 32'd0);
        chk("s6_rst_cycles", run_cycles, 32'd0);
        reset = 1'b0;
        wq0 = wr_addr_q.size();
        issue(8, 2);
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_valid = 1'b0;
        chk("s6_start_port", 32'(start_port), 32'd1);
        chk("s6_wr_addr0", 32'(wr_addr_q[wq0]), 32'd8);
        chk("s6_wr_addr1", 32'(wr_addr_q[wq0 + 1]), 32'd9);
        tick();
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        chk("s6_run_cycles", run_cycles, 32'd2);
        wait_out("s6_out_timeout");
        chk("s6_out0", 32'(out_data), 32'h11);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        wait_out("s6_out_timeout");
        chk("s6_out1", 32'(out_data), 32'h22);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("s6_run_done", 32'(run_done), 32'd1);
        chk("s6_run_err", 32'(run_err), 32'd0);
        tick();

        chk("oe_we_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
